// File: rtl/fsm_pkg.sv
// Shared state encoding for the parametrised link-layer FIFO controller.
package fsm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/fsm_idle_timer.sv
// Debounce counter: expires after IDLE_DLY consecutive all-empty cycles.
module fsm_idle_timer #(
    parameter int IDLE_DLY = 3
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clr,
    input  logic all_empty,
    output logic expired
);

    localparam int CNT_W = $clog2(IDLE_DLY) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IDLE_DLY - 1);

    logic [CNT_W-1:0] count;

    assign expired = all_empty && (count == LAST);

    // Any non-empty cycle breaks the run; wrapping on expiry keeps count <= IDLE_DLY-1.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
        end else if (clr || !all_empty || expired) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fsm_ctrl_param.sv
// FIFO bank control FSM: RESET -> INIT -> IDLE/ACTIVE with sticky ERROR,
// threshold latching during INIT and debounced return to IDLE.
module fsm_ctrl_param
    import fsm_pkg::*;
#(
    parameter int NUM_FIFOS = 10,
    parameter int UMBRAL_W  = 4,
    parameter int IDLE_DLY  = 3
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [NUM_FIFOS-1:0] empties,
    input  logic [NUM_FIFOS-1:0] fifo_err,
    input  logic [UMBRAL_W-1:0]  umbral_interno_L,
    input  logic [UMBRAL_W-1:0]  umbral_interno_H,
    output logic                 INIT_OUT,
    output logic                 IDLE_OUT,
    output logic                 ACTIVE_OUT,
    output logic                 ERROR_OUT,
    output logic                 cfg_err_out,
    output logic [NUM_FIFOS-1:0] error_vec_out,
    output logic [UMBRAL_W-1:0]  umbral_out_L,
    output logic [UMBRAL_W-1:0]  umbral_out_H
);

    state_t                state;
    logic [UMBRAL_W-1:0]   umbral_L;
    logic [UMBRAL_W-1:0]   umbral_H;
    logic [NUM_FIFOS-1:0]  error_vec;
    logic                  all_empty;
    logic                  any_err;
    logic                  cfg_bad;
    logic                  timer_clr;
    logic                  expired;

    assign all_empty = &empties;
    assign any_err   = |fifo_err;
    assign cfg_bad   = umbral_interno_L > umbral_interno_H;
    assign timer_clr = (state != ST_ACTIVE) || init || any_err;

    fsm_idle_timer #(
        .IDLE_DLY (IDLE_DLY)
    ) u_idle_timer (
        .clk       (clk),
        .reset_L   (reset_L),
        .clr       (timer_clr),
        .all_empty (all_empty),
        .expired   (expired)
    );

    // init outranks fifo_err, which outranks empties; ERROR only leaves via init.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= ST_RESET;
            umbral_L  <= '0;
            umbral_H  <= '0;
            error_vec <= '0;
        end else begin
            if (state == ST_INIT) begin
                umbral_L <= umbral_interno_L;
                umbral_H <= umbral_interno_H;
            end
            if (state != ST_RESET && init) begin
                state     <= ST_INIT;
                error_vec <= '0;
            end else begin
                case (state)
                    ST_RESET: state <= ST_INIT;
                    ST_INIT: begin
                        if (!cfg_bad) state <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (any_err) begin
                            state     <= ST_ERROR;
                            error_vec <= error_vec | fifo_err;
                        end else if (!all_empty) begin
                            state <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (any_err) begin
                            state     <= ST_ERROR;
                            error_vec <= error_vec | fifo_err;
                        end else if (expired) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_ERROR: error_vec <= error_vec | fifo_err;
                    default:  state <= ST_INIT;
                endcase
            end
        end
    end

    assign INIT_OUT      = (state == ST_INIT);
    assign IDLE_OUT      = (state == ST_IDLE);
    assign ACTIVE_OUT    = (state == ST_ACTIVE);
    assign ERROR_OUT     = (state == ST_ERROR);
    assign cfg_err_out   = INIT_OUT && cfg_bad;
    assign error_vec_out = error_vec;

    // While configuring, the FIFO bank sees the live thresholds.
    assign umbral_out_L = INIT_OUT ? umbral_interno_L : umbral_L;
    assign umbral_out_H = INIT_OUT ? umbral_interno_H : umbral_H;

endmodule

// File: tb/tb_fsm_ctrl_param.sv
// Self-checking bench for fsm_ctrl_param: directed vector table, async reset
// sequence, then random stimulus against a behavioural model.
module tb_fsm_ctrl_param;

    localparam int NF  = 10;
    localparam int UW  = 4;
    localparam int DLY = 3;
    localparam logic [NF-1:0] ALL_EMPTY = {NF{1'b1}};

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INIT = 4'b1000;
    localparam logic [3:0] F_IDLE = 4'b0100;
    localparam logic [3:0] F_ACT  = 4'b0010;
    localparam logic [3:0] F_ERR  = 4'b0001;

    localparam int M_RST  = 0;
    localparam int M_INIT = 1;
    localparam int M_IDLE = 2;
    localparam int M_ACT  = 3;
    localparam int M_ERR  = 4;

    typedef struct packed {
        logic [3:0]    fl;
        logic          cfg;
        logic [NF-1:0] ev;
        logic [UW-1:0] ul;
        logic [UW-1:0] uh;
    } out_t;

    typedef struct packed {
        logic          init;
        logic [NF-1:0] emp;
        logic [NF-1:0] ferr;
        logic [UW-1:0] l;
        logic [UW-1:0] h;
        out_t          exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_L = 1'b1;
    logic          init = 1'b0;
    logic [NF-1:0] empties = ALL_EMPTY;
    logic [NF-1:0] fifo_err = '0;
    logic [UW-1:0] umbral_interno_L = '0;
    logic [UW-1:0] umbral_interno_H = '0;
    logic          INIT_OUT, IDLE_OUT, ACTIVE_OUT, ERROR_OUT, cfg_err_out;
    logic [NF-1:0] error_vec_out;
    logic [UW-1:0] umbral_out_L, umbral_out_H;

    int assert_count = 0;
    int fail_count   = 0;

    int            m_mode;
    int            m_run;
    logic [UW-1:0] m_lo, m_hi;
    logic [NF-1:0] m_errs;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fsm_ctrl_param #(
        .NUM_FIFOS (NF),
        .UMBRAL_W  (UW),
        .IDLE_DLY  (DLY)
    ) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .init             (init),
        .empties          (empties),
        .fifo_err         (fifo_err),
        .umbral_interno_L (umbral_interno_L),
        .umbral_interno_H (umbral_interno_H),
        .INIT_OUT         (INIT_OUT),
        .IDLE_OUT         (IDLE_OUT),
        .ACTIVE_OUT       (ACTIVE_OUT),
        .ERROR_OUT        (ERROR_OUT),
        .cfg_err_out      (cfg_err_out),
        .error_vec_out    (error_vec_out),
        .umbral_out_L     (umbral_out_L),
        .umbral_out_H     (umbral_out_H)
    );

    function automatic vec_t mkVec(input logic i, input logic [NF-1:0] e, input logic [NF-1:0] f,
                                   input logic [UW-1:0] l, input logic [UW-1:0] h,
                                   input logic [3:0] fl, input logic cfg, input logic [NF-1:0] ev,
                                   input logic [UW-1:0] ul, input logic [UW-1:0] uh);
        vec_t v;
        v.init = i; v.emp = e; v.ferr = f; v.l = l; v.h = h;
        v.exp.fl = fl; v.exp.cfg = cfg; v.exp.ev = ev; v.exp.ul = ul; v.exp.uh = uh;
        return v;
    endfunction

    task automatic modelReset();
        m_mode = M_RST;
        m_run  = 0;
        m_lo   = '0;
        m_hi   = '0;
        m_errs = '0;
    endtask

    // One clock edge of the link controller, described by its rules.
    task automatic modelStep(input logic i, input logic [NF-1:0] e, input logic [NF-1:0] f,
                             input logic [UW-1:0] l, input logic [UW-1:0] h);
        int next_mode;
        next_mode = m_mode;
        if (m_mode == M_INIT) begin
            m_lo = l;
            m_hi = h;
        end
        if (m_mode != M_RST && i) begin
            next_mode = M_INIT;
            m_errs    = '0;
            m_run     = 0;
        end else if (m_mode == M_RST) begin
            next_mode = M_INIT;
        end else if (m_mode == M_INIT) begin
            if (int'(l) <= int'(h)) next_mode = M_IDLE;
        end else if (m_mode == M_ERR) begin
            m_errs = m_errs | f;
        end else if (f != '0) begin
            m_errs    = m_errs | f;
            next_mode = M_ERR;
        end else if (m_mode == M_IDLE) begin
            if (e != ALL_EMPTY) begin
                next_mode = M_ACT;
                m_run     = 0;
            end
        end else if (m_mode == M_ACT) begin
            if (e == ALL_EMPTY) begin
                m_run = m_run + 1;
                if (m_run >= DLY) begin
                    next_mode = M_IDLE;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            next_mode = M_INIT;
        end
        m_mode = next_mode;
    endtask

    function automatic out_t modelExpect();
        out_t o;
        o.fl  = (m_mode == M_INIT) ? F_INIT :
                (m_mode == M_IDLE) ? F_IDLE :
                (m_mode == M_ACT)  ? F_ACT  :
                (m_mode == M_ERR)  ? F_ERR  : F_NONE;
        o.cfg = (m_mode == M_INIT) && (int'(umbral_interno_L) > int'(umbral_interno_H));
        o.ev  = m_errs;
        o.ul  = (m_mode == M_INIT) ? umbral_interno_L : m_lo;
        o.uh  = (m_mode == M_INIT) ? umbral_interno_H : m_hi;
        return o;
    endfunction

    function automatic out_t getActual();
        out_t o;
        o.fl  = {INIT_OUT, IDLE_OUT, ACTIVE_OUT, ERROR_OUT};
        o.cfg = cfg_err_out;
        o.ev  = error_vec_out;
        o.ul  = umbral_out_L;
        o.uh  = umbral_out_H;
        return o;
    endfunction

    // Drive inputs, take one rising edge (model steps with it), settle at the falling edge.
    task automatic applyStimulus(input logic i, input logic [NF-1:0] e, input logic [NF-1:0] f,
                                 input logic [UW-1:0] l, input logic [UW-1:0] h);
        init             = i;
        empties          = e;
        fifo_err         = f;
        umbral_interno_L = l;
        umbral_interno_H = h;
        @(posedge clk);
        modelStep(i, e, f, l, h);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = getActual();
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got flags=%b cfg=%b ev=%h L=%0d H=%0d, expected flags=%b cfg=%b ev=%h L=%0d H=%0d",
                     name, act.fl, act.cfg, act.ev, act.ul, act.uh,
                     exp.fl, exp.cfg, exp.ev, exp.ul, exp.uh);
        end
    endtask

    initial begin
        out_t zero;
        out_t ex;
        logic [NF-1:0] e, f;
        zero = '0;

        modelReset();
        init             = 1'b1;
        umbral_interno_L = 4'd3;
        umbral_interno_H = 4'd12;
        #1 reset_L = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", zero);
        reset_L = 1'b1;

        vecs.push_back(mkVec(1, 10'h3FF, 10'h000,  3, 12, F_INIT, 0, 10'h000,  3, 12));
        vecs.push_back(mkVec(1, 10'h3FF, 10'h000,  3, 12, F_INIT, 0, 10'h000,  3, 12));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  3, 12, F_IDLE, 0, 10'h000,  3, 12));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  0,  0, F_IDLE, 0, 10'h000,  3, 12));
        vecs.push_back(mkVec(1, 10'h3FF, 10'h000,  0,  0, F_INIT, 0, 10'h000,  0,  0));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  9,  4, F_INIT, 1, 10'h000,  9,  4));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  9, 10, F_IDLE, 0, 10'h000,  9, 10));
        vecs.push_back(mkVec(0, 10'h3FE, 10'h000,  0,  0, F_ACT,  0, 10'h000,  9, 10));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  0,  0, F_ACT,  0, 10'h000,  9, 10));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  0,  0, F_ACT,  0, 10'h000,  9, 10));
        vecs.push_back(mkVec(0, 10'h3F7, 10'h000,  0,  0, F_ACT,  0, 10'h000,  9, 10));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  0,  0, F_ACT,  0, 10'h000,  9, 10));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  0,  0, F_ACT,  0, 10'h000,  9, 10));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  0,  0, F_IDLE, 0, 10'h000,  9, 10));
        vecs.push_back(mkVec(0, 10'h0FF, 10'h000,  0,  0, F_ACT,  0, 10'h000,  9, 10));
        vecs.push_back(mkVec(0, 10'h0FF, 10'h004,  0,  0, F_ERR,  0, 10'h004,  9, 10));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h200,  0,  0, F_ERR,  0, 10'h204,  9, 10));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  0,  0, F_ERR,  0, 10'h204,  9, 10));
        vecs.push_back(mkVec(1, 10'h3FF, 10'h000,  0,  0, F_INIT, 0, 10'h000,  0,  0));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  5,  5, F_IDLE, 0, 10'h000,  5,  5));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h001,  0,  0, F_ERR,  0, 10'h001,  5,  5));
        vecs.push_back(mkVec(1, 10'h3FF, 10'h002,  5,  5, F_INIT, 0, 10'h000,  5,  5));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h3FF, 15,  0, F_INIT, 1, 10'h000, 15,  0));
        vecs.push_back(mkVec(0, 10'h3FF, 10'h000,  0, 15, F_IDLE, 0, 10'h000,  0, 15));

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].init, vecs[k].emp, vecs[k].ferr, vecs[k].l, vecs[k].h);
            checkOutput($sformatf("vec_%0d", k), vecs[k].exp);
        end

        // Reset asserted between edges must clear everything without a clock.
        applyStimulus(0, 10'h3FE, 10'h000, 0, 15);
        ex = '0; ex.fl = F_ACT; ex.uh = 4'd15;
        checkOutput("pre_reset_active", ex);
        #2 reset_L = 1'b0;
        #1 checkOutput("async_reset_immediate", zero);
        modelReset();
        @(negedge clk);
        checkOutput("async_reset_held", zero);
        reset_L = 1'b1;
        applyStimulus(0, 10'h3FF, 10'h000, 0, 15);
        ex = '0; ex.fl = F_INIT; ex.uh = 4'd15;
        checkOutput("post_reset_init", ex);
        applyStimulus(0, 10'h3FF, 10'h000, 2, 7);
        ex = '0; ex.fl = F_IDLE; ex.ul = 4'd2; ex.uh = 4'd7;
        checkOutput("post_reset_idle", ex);

        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    e = ALL_EMPTY;
                2:       e = ALL_EMPTY & ~(NF'(1) << $urandom_range(0, NF - 1));
                default: e = NF'($urandom);
            endcase
            f = ($urandom_range(0, 15) == 0) ? (NF'(1) << $urandom_range(0, NF - 1)) : '0;
            applyStimulus(($urandom_range(0, 40) == 0), e, f, UW'($urandom), UW'($urandom));
            checkOutput($sformatf("rand_%0d", n), modelExpect());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
